// File: rtl/irq_pkg.sv
// Shared constants and types for the eight-source interrupt capture block.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-to-3 priority encoder; bit 7 wins, index is 0 when empty.
module pri_enc8
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Highest set bit selects the index.
  always_comb begin
    any = |vec;
    casez (vec)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_capture8.sv
// Rising-edge interrupt capture with pending/mask registers and a
// valid/ready offer of the highest-priority unmasked pending source.
module irq_capture8
  import irq_pkg::*;
#(
  parameter logic [N_SRC-1:0] RESET_MASK = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req_i,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pend_q,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [IDX_W-1:0] irq_idx,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [N_SRC-1:0] req_d;
  logic [N_SRC-1:0] req_edge;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] clr;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             accept;
  logic             ovf_hit;
  irq_state_t       state;

  assign mask_q = mask;
  assign pend_q = pend;

  // Edge detection, acceptance decode and the active (unmasked) pending set.
  always_comb begin
    req_edge = req_i & ~req_d;
    act      = pend & ~mask;
    accept   = (state == OFFER) & irq_ready;
    if (accept) begin
      clr = 8'b0000_0001 << irq_idx;
    end else begin
      clr = 8'b0000_0000;
    end
    // A new edge on a bit being cleared this cycle counts as a fresh event.
    ovf_hit  = |(req_edge & pend & ~clr);
  end

  pri_enc8 u_enc (
    .vec (act),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Edge history, pending, mask and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d    <= 8'hFF;
      pend     <= 8'h00;
      mask     <= RESET_MASK;
      overflow <= 1'b0;
    end else begin
      req_d <= req_i;
      pend  <= (pend & ~clr) | req_edge;
      if (mask_wr) begin
        mask <= mask_din;
      end
      if (ovf_hit) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Offer FSM: priority is sampled only in IDLE and held stable while offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_any) begin
            state     <= OFFER;
            irq_valid <= 1'b1;
            irq_idx   <= enc_idx;
          end
        end
        OFFER: begin
          if (irq_ready) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
